// File: rtl/board_state_engine.sv
// Chess board state holder with a circular undo history for moves, castling and en passant.
// Optional PROMOTION_EN: pawns reaching the last rank are written as queens.
module board_state_engine #(
    parameter int unsigned HIST_DEPTH = 16,
    parameter int unsigned PIECE_W    = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        init,
    input  logic                        move_valid,
    output logic                        move_ready,
    input  logic [5:0]                  from_sq,
    input  logic [5:0]                  to_sq,
    input  logic [5:0]                  moving_piece,
    input  logic [5:0]                  captured_piece,
    input  logic [2:0]                  castling,
    input  logic [4:0]                  enpassant,
    input  logic                        color_type,
    input  logic                        undo_valid,
    output logic                        undo_ready,
    input  logic [5:0]                  rd_sq,
    output logic [PIECE_W-1:0]          rd_piece,
    output logic                        busy,
    output logic [$clog2(HIST_DEPTH):0] hist_count,
    output logic                        err
);
    localparam int unsigned PW = $clog2(HIST_DEPTH);

    localparam logic [4:0] T_PAWN   = 5'b00010;
    localparam logic [4:0] T_KNIGHT = 5'b00001;
    localparam logic [4:0] T_KING   = 5'b00100;
    localparam logic [4:0] T_QUEEN  = 5'b11000;
    localparam logic [4:0] T_ROOK   = 5'b10000;
    localparam logic [4:0] T_BISHOP = 5'b01000;

    typedef enum logic [2:0] {IDLE, APPLY, SIDE, PUSH, POP, RESTORE} state_t;

    typedef struct packed {
        logic [5:0]         from;
        logic [5:0]         to;
        logic [PIECE_W-1:0] moved;
        logic [PIECE_W-1:0] captured;
        logic [2:0]         castling;
        logic               ep;
    } histEntry_t;

    function automatic logic [PIECE_W-1:0] mkCode(input logic c, input logic [4:0] t);
        mkCode = '0;
        mkCode[PIECE_W-1] = c;
        mkCode[4:0] = t;
    endfunction

    function automatic logic [4:0] typeOf(input logic [5:0] oh);
        case (oh)
            6'b000001: typeOf = T_PAWN;
            6'b000010: typeOf = T_ROOK;
            6'b000100: typeOf = T_KNIGHT;
            6'b001000: typeOf = T_BISHOP;
            6'b010000: typeOf = T_QUEEN;
            6'b100000: typeOf = T_KING;
            default:   typeOf = 5'b00000;
        endcase
    endfunction

    function automatic logic [PIECE_W-1:0] startPiece(input logic [5:0] sq);
        logic [4:0] backType;
        case (sq[2:0])
            3'd0, 3'd7: backType = T_ROOK;
            3'd1, 3'd6: backType = T_KNIGHT;
            3'd2, 3'd5: backType = T_BISHOP;
            3'd3:       backType = T_QUEEN;
            default:    backType = T_KING;
        endcase
        case (sq[5:3])
            3'd0:    startPiece = mkCode(1'b0, backType);
            3'd1:    startPiece = mkCode(1'b0, T_PAWN);
            3'd6:    startPiece = mkCode(1'b1, T_PAWN);
            3'd7:    startPiece = mkCode(1'b1, backType);
            default: startPiece = '0;
        endcase
    endfunction

    state_t             state;
    logic [PIECE_W-1:0] board [64];
    histEntry_t         hist [HIST_DEPTH];
    histEntry_t         cur;
    logic [PW-1:0]      wrPtr;
    logic [PW-1:0]      lastPtr;
    logic [PW:0]        count;
    logic               undoOp;
    logic               castleK, castleQ, sideNeeded;
    logic               moverColor;
    logic [2:0]         rank;
    logic [5:0]         epSq;
    logic [PIECE_W-1:0] rookCode;
    logic [PIECE_W-1:0] placedCode;
    logic [PIECE_W-1:0] capturedCode;

    assign lastPtr      = wrPtr - 1'b1;
    assign castleK      = (cur.castling == 3'b100);
    assign castleQ      = (cur.castling == 3'b010);
    assign sideNeeded   = castleK | castleQ | cur.ep;
    assign moverColor   = cur.moved[PIECE_W-1];
    assign rank         = cur.from[5:3];
    assign epSq         = {cur.from[5:3], cur.to[2:0]};
    assign rookCode     = mkCode(moverColor, T_ROOK);
    assign capturedCode = (captured_piece == 6'b000000) ? '0
                        : mkCode(~color_type, typeOf(captured_piece));

`ifdef PROMOTION_EN
    // History keeps the original pawn code, so undo naturally demotes the queen.
    logic promote;
    assign promote    = (cur.moved[4:0] == T_PAWN) &&
                        (moverColor ? (cur.to[5:3] == 3'd0) : (cur.to[5:3] == 3'd7));
    assign placedCode = promote ? mkCode(moverColor, T_QUEEN) : cur.moved;
`else
    assign placedCode = cur.moved;
`endif

    assign move_ready = (state == IDLE);
    assign undo_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign hist_count = count;
    assign rd_piece   = board[rd_sq];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 64; i++) board[i] <= startPiece(6'(i));
            state  <= IDLE;
            wrPtr  <= '0;
            count  <= '0;
            err    <= 1'b0;
            cur    <= '0;
            undoOp <= 1'b0;
        end else begin
            err <= 1'b0;
            if (init) begin
                for (int unsigned i = 0; i < 64; i++) board[i] <= startPiece(6'(i));
                state  <= IDLE;
                wrPtr  <= '0;
                count  <= '0;
                undoOp <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (undo_valid) begin
                            if (count == '0) begin
                                err <= 1'b1;
                            end else begin
                                undoOp <= 1'b1;
                                state  <= POP;
                            end
                        end else if (move_valid) begin
                            if (!$onehot(moving_piece)) begin
                                err <= 1'b1;
                            end else begin
                                cur <= '{from: from_sq, to: to_sq,
                                         moved: mkCode(color_type, typeOf(moving_piece)),
                                         captured: capturedCode, castling: castling,
                                         ep: (enpassant != 5'b00001)};
                                undoOp <= 1'b0;
                                state  <= APPLY;
                            end
                        end
                    end
                    APPLY: begin
                        board[cur.from] <= '0;
                        board[cur.to]   <= placedCode;
                        state <= sideNeeded ? SIDE : PUSH;
                    end
                    // Shared by move (forward rook / capture removal) and undo (reverse).
                    SIDE: begin
                        if (!undoOp) begin
                            if (castleK) begin
                                board[{rank, 3'd7}] <= '0;
                                board[{rank, 3'd5}] <= rookCode;
                            end else if (castleQ) begin
                                board[{rank, 3'd0}] <= '0;
                                board[{rank, 3'd3}] <= rookCode;
                            end else begin
                                board[epSq] <= '0;
                            end
                            state <= PUSH;
                        end else begin
                            if (castleK) begin
                                board[{rank, 3'd5}] <= '0;
                                board[{rank, 3'd7}] <= rookCode;
                            end else if (castleQ) begin
                                board[{rank, 3'd3}] <= '0;
                                board[{rank, 3'd0}] <= rookCode;
                            end else begin
                                board[epSq] <= mkCode(~moverColor, T_PAWN);
                            end
                            state <= IDLE;
                        end
                    end
                    PUSH: begin
                        wrPtr <= wrPtr + 1'b1;
                        if (count != (PW+1)'(HIST_DEPTH)) count <= count + 1'b1;
                        state <= IDLE;
                    end
                    POP: begin
                        cur   <= hist[lastPtr];
                        wrPtr <= lastPtr;
                        count <= count - 1'b1;
                        state <= RESTORE;
                    end
                    RESTORE: begin
                        board[cur.from] <= cur.moved;
                        board[cur.to]   <= cur.ep ? '0 : cur.captured;
                        state <= sideNeeded ? SIDE : IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == PUSH && !init) hist[wrPtr] <= cur;
    end
endmodule

// File: tb/tb_board_state_engine.sv
// Directed self-checking bench for board_state_engine (default depth plus a depth-2 instance).
module tb_board_state_engine;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init = 1'b0;
    logic       move_valid = 1'b0;
    logic       undo_valid = 1'b0;
    logic [5:0] from_sq = '0, to_sq = '0, moving_piece = '0, captured_piece = '0;
    logic [2:0] castling = 3'b001;
    logic [4:0] enpassant = 5'b00001;
    logic       color_type = 1'b0;
    logic [5:0] rd_sq = '0;

    logic       move_ready, undo_ready, busy, err;
    logic [5:0] rd_piece;
    logic [4:0] hist_count;
    logic       moveReadyS, undoReadyS, busyS, errS;
    logic [5:0] rdPieceS;
    logic [1:0] histCountS;

    int passed = 0;
    int total  = 0;

    localparam logic [5:0] P_PAWN = 6'b000001, P_ROOK = 6'b000010, P_KNIGHT = 6'b000100,
                           P_BISHOP = 6'b001000, P_KING = 6'b100000;

    board_state_engine dut (
        .clk(clk), .rst_n(rst_n), .init(init), .move_valid(move_valid), .move_ready(move_ready),
        .from_sq(from_sq), .to_sq(to_sq), .moving_piece(moving_piece),
        .captured_piece(captured_piece), .castling(castling), .enpassant(enpassant),
        .color_type(color_type), .undo_valid(undo_valid), .undo_ready(undo_ready),
        .rd_sq(rd_sq), .rd_piece(rd_piece), .busy(busy), .hist_count(hist_count), .err(err)
    );

    board_state_engine #(.HIST_DEPTH(2)) dutSmall (
        .clk(clk), .rst_n(rst_n), .init(init), .move_valid(move_valid), .move_ready(moveReadyS),
        .from_sq(from_sq), .to_sq(to_sq), .moving_piece(moving_piece),
        .captured_piece(captured_piece), .castling(castling), .enpassant(enpassant),
        .color_type(color_type), .undo_valid(undo_valid), .undo_ready(undoReadyS),
        .rd_sq(rd_sq), .rd_piece(rdPieceS), .busy(busyS), .hist_count(histCountS), .err(errS)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] sq;
        logic [5:0] exp;
    } rdVec_t;
    rdVec_t resetTab[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic readSq(input string name, input logic [5:0] sq, input logic [5:0] exp);
        rd_sq = sq;
        #1;
        check(name, 32'(rd_piece), 32'(exp));
    endtask

    task automatic readSqS(input string name, input logic [5:0] sq, input logic [5:0] exp);
        rd_sq = sq;
        #1;
        check(name, 32'(rdPieceS), 32'(exp));
    endtask

    task automatic pulseInit();
        @(negedge clk); init = 1'b1;
        @(posedge clk); #1; init = 1'b0;
    endtask

    task automatic doMove(input logic [5:0] f, input logic [5:0] t, input logic [5:0] mp,
                          input logic [5:0] cp, input logic [2:0] cs, input logic [4:0] ep,
                          input logic c, output int lat);
        @(negedge clk);
        from_sq = f; to_sq = t; moving_piece = mp; captured_piece = cp;
        castling = cs; enpassant = ep; color_type = c; move_valid = 1'b1;
        @(posedge clk); #1;
        move_valid = 1'b0; castling = 3'b001; enpassant = 5'b00001;
        lat = 0;
        while (!move_ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic doUndo(output int lat, output logic errSeen, output logic errSeenS);
        @(negedge clk);
        undo_valid = 1'b1;
        @(posedge clk); #1;
        undo_valid = 1'b0;
        errSeen = err;
        errSeenS = errS;
        lat = 0;
        while (!undo_ready && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic e, es;

        resetTab[0]  = '{6'd0,  6'b010000};
        resetTab[1]  = '{6'd1,  6'b000001};
        resetTab[2]  = '{6'd2,  6'b001000};
        resetTab[3]  = '{6'd3,  6'b011000};
        resetTab[4]  = '{6'd4,  6'b000100};
        resetTab[5]  = '{6'd7,  6'b010000};
        resetTab[6]  = '{6'd8,  6'b000010};
        resetTab[7]  = '{6'd20, 6'b000000};
        resetTab[8]  = '{6'd48, 6'b100010};
        resetTab[9]  = '{6'd60, 6'b100100};
        resetTab[10] = '{6'd63, 6'b110000};
        resetTab[11] = '{6'd59, 6'b111000};

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_count", 32'(hist_count), 0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        check("rst_ready", 32'(move_ready), 1);
        for (int i = 0; i < 12; i++) readSq($sformatf("rst_sq%0d", resetTab[i].sq), resetTab[i].sq, resetTab[i].exp);

        // Quiet pawn move
        doMove(6'd12, 6'd28, P_PAWN, 6'd0, 3'b001, 5'b00001, 1'b0, lat);
        check("quiet_lat", 32'(lat), 2);
        readSq("quiet_28", 6'd28, 6'b000010);
        readSq("quiet_12", 6'd12, 6'b000000);
        check("quiet_count", 32'(hist_count), 1);

        // King-side castle after clearing f1/g1
        pulseInit();
        doMove(6'd6, 6'd21, P_KNIGHT, 6'd0, 3'b001, 5'b00001, 1'b0, lat);
        doMove(6'd5, 6'd26, P_BISHOP, 6'd0, 3'b001, 5'b00001, 1'b0, lat);
        doMove(6'd4, 6'd6, P_KING, 6'd0, 3'b100, 5'b00001, 1'b0, lat);
        check("castle_lat", 32'(lat), 3);
        readSq("castle_6", 6'd6, 6'b000100);
        readSq("castle_5", 6'd5, 6'b010000);
        readSq("castle_7", 6'd7, 6'b000000);
        readSq("castle_4", 6'd4, 6'b000000);
        doUndo(lat, e, es);
        check("ucastle_lat", 32'(lat), 3);
        readSq("ucastle_4", 6'd4, 6'b000100);
        readSq("ucastle_7", 6'd7, 6'b010000);
        readSq("ucastle_5", 6'd5, 6'b000000);
        check("ucastle_count", 32'(hist_count), 2);
        doUndo(lat, e, es);
        doUndo(lat, e, es);
        readSq("ucastle_5b", 6'd5, 6'b001000);
        readSq("ucastle_6b", 6'd6, 6'b000001);
        readSq("ucastle_26", 6'd26, 6'b000000);
        check("ucastle_count0", 32'(hist_count), 0);

        // En passant
        pulseInit();
        doMove(6'd12, 6'd36, P_PAWN, 6'd0, 3'b001, 5'b00001, 1'b0, lat);
        doMove(6'd51, 6'd35, P_PAWN, 6'd0, 3'b001, 5'b00001, 1'b1, lat);
        doMove(6'd36, 6'd43, P_PAWN, P_PAWN, 3'b001, 5'b00010, 1'b0, lat);
        check("ep_lat", 32'(lat), 3);
        readSq("ep_35", 6'd35, 6'b000000);
        readSq("ep_43", 6'd43, 6'b000010);
        readSq("ep_36", 6'd36, 6'b000000);
        doUndo(lat, e, es);
        readSq("uep_35", 6'd35, 6'b100010);
        readSq("uep_36", 6'd36, 6'b000010);
        readSq("uep_43", 6'd43, 6'b000000);
        check("uep_count", 32'(hist_count), 2);

        // Undo on empty history
        pulseInit();
        doUndo(lat, e, es);
        check("empty_err", 32'(e), 1);
        check("empty_ready", 32'(undo_ready), 1);
        @(posedge clk); #1;
        check("empty_err_clr", 32'(err), 0);
        readSq("empty_12", 6'd12, 6'b000010);
        check("empty_count", 32'(hist_count), 0);

        // Move and undo requested together: undo wins
        doMove(6'd12, 6'd28, P_PAWN, 6'd0, 3'b001, 5'b00001, 1'b0, lat);
        @(negedge clk);
        from_sq = 6'd11; to_sq = 6'd27; moving_piece = P_PAWN; captured_piece = '0;
        color_type = 1'b0; move_valid = 1'b1; undo_valid = 1'b1;
        @(posedge clk); #1;
        move_valid = 1'b0; undo_valid = 1'b0;
        lat = 0;
        while (!undo_ready && lat < 20) begin @(posedge clk); #1; lat++; end
        readSq("both_12", 6'd12, 6'b000010);
        readSq("both_27", 6'd27, 6'b000000);
        readSq("both_11", 6'd11, 6'b000010);
        check("both_count", 32'(hist_count), 0);

        // Non-one-hot moving piece rejected
        @(negedge clk);
        from_sq = 6'd12; to_sq = 6'd20; moving_piece = 6'b000011; move_valid = 1'b1;
        @(posedge clk); #1;
        move_valid = 1'b0;
        check("bad_err", 32'(err), 1);
        check("bad_ready", 32'(move_ready), 1);
        readSq("bad_20", 6'd20, 6'b000000);
        check("bad_count", 32'(hist_count), 0);

        // Pawn on the last rank
        doMove(6'd8, 6'd56, P_PAWN, P_ROOK, 3'b001, 5'b00001, 1'b0, lat);
`ifdef PROMOTION_EN
        readSq("promo_56", 6'd56, 6'b011000);
`else
        readSq("promo_56", 6'd56, 6'b000010);
`endif
        doUndo(lat, e, es);
        readSq("upromo_56", 6'd56, 6'b110000);
        readSq("upromo_8", 6'd8, 6'b000010);

        // init while in SIDE
        pulseInit();
        @(negedge clk);
        from_sq = 6'd4; to_sq = 6'd6; moving_piece = P_KING; captured_piece = '0;
        castling = 3'b100; color_type = 1'b0; move_valid = 1'b1;
        @(posedge clk); #1;
        move_valid = 1'b0; castling = 3'b001;
        @(posedge clk); #1;
        check("side_busy", 32'(busy), 1);
        @(negedge clk); init = 1'b1;
        @(posedge clk); #1; init = 1'b0;
        check("init_ready", 32'(move_ready), 1);
        check("init_busy", 32'(busy), 0);
        check("init_count", 32'(hist_count), 0);
        readSq("init_4", 6'd4, 6'b000100);
        readSq("init_6", 6'd6, 6'b000001);
        readSq("init_7", 6'd7, 6'b010000);

        // Depth-2 history wrap
        pulseInit();
        doMove(6'd12, 6'd28, P_PAWN, 6'd0, 3'b001, 5'b00001, 1'b0, lat);
        doMove(6'd52, 6'd36, P_PAWN, 6'd0, 3'b001, 5'b00001, 1'b1, lat);
        doMove(6'd11, 6'd27, P_PAWN, 6'd0, 3'b001, 5'b00001, 1'b0, lat);
        check("wrap_countS", 32'(histCountS), 2);
        check("wrap_count", 32'(hist_count), 3);
        doUndo(lat, e, es);
        check("wrap_u1_err", 32'(es), 0);
        check("wrap_u1_count", 32'(histCountS), 1);
        doUndo(lat, e, es);
        check("wrap_u2_err", 32'(es), 0);
        check("wrap_u2_count", 32'(histCountS), 0);
        doUndo(lat, e, es);
        check("wrap_u3_err", 32'(es), 1);
        check("wrap_main_err", 32'(e), 0);
        check("wrap_countS_end", 32'(histCountS), 0);
        check("wrap_count_end", 32'(hist_count), 0);
        readSqS("wrapS_28", 6'd28, 6'b000010);
        readSqS("wrapS_12", 6'd12, 6'b000000);
        readSqS("wrapS_52", 6'd52, 6'b100010);
        readSqS("wrapS_11", 6'd11, 6'b000010);
        readSq("wrap_12", 6'd12, 6'b000010);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/board_state_engine.md
BOARD_STATE_ENGINE -- requirements
Module: board_state_engine

Interface
REQ-001 The block SHALL have parameter HIST_DEPTH, default 16, giving the number of undo-history entries; it must be a power of two, at least 2.
REQ-002 The block SHALL have parameter PIECE_W, default 6, giving the piece code width: {color, 5-bit type}.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 init  in  1  synchronous reload of the start position and clear of history.
REQ-006 move_valid/move_ready  in/out  1/1  move request handshake.
REQ-007 from_sq, to_sq  in  6/6  square indices; file = sq[2:0], rank = sq[5:3].
REQ-008 moving_piece, captured_piece  in  6/6  one-hot: 000001 pawn, 000010 rook, 000100 knight, 001000 bishop, 010000 queen, 100000 king; captured 000000 means quiet.
REQ-009 castling  in  3  001 none, 010 queen side, 100 king side.
REQ-010 enpassant  in  5  00001 none; any other value means en-passant capture.
REQ-011 color_type  in  1  mover colour: 0 white, 1 black.
REQ-012 undo_valid/undo_ready  in/out  1/1  undo request handshake.
REQ-013 rd_sq  in  6; rd_piece  out  PIECE_W  combinational board read port.
REQ-014 busy  out  1; hist_count  out  $clog2(HIST_DEPTH)+1; err  out  1 (one-cycle pulse).

Function
REQ-015 Type codes SHALL be: pawn 00010, knight 00001, king 00100, queen 11000, rook 10000, bishop 01000; an empty square SHALL read 000000.
REQ-016 The FSM states SHALL be IDLE, APPLY, SIDE, PUSH, POP and RESTORE; move_ready and undo_ready SHALL be high only in IDLE.
REQ-017 Accepting a move SHALL sequence IDLE->APPLY->PUSH->IDLE, or IDLE->APPLY->SIDE->PUSH->IDLE when castling or en passant applies. busy SHALL be high outside IDLE.
REQ-018 APPLY SHALL clear from_sq and write {color_type, type} to to_sq.
REQ-019 For castling, SIDE SHALL move the rook on from_sq's rank: king side file 7->5, queen side file 0->3.
REQ-020 For en passant, SIDE SHALL clear square {from_sq[5:3], to_sq[2:0]}.
REQ-021 PUSH SHALL store {from, to, moved code, captured code, castling, ep flag} in a circular buffer; when HIST_DEPTH entries are held, the oldest entry SHALL be overwritten and hist_count SHALL saturate at HIST_DEPTH.
REQ-022 Undo SHALL sequence IDLE->POP->RESTORE->IDLE, with one extra SIDE-like cycle before IDLE for castling or en passant, and SHALL decrement hist_count.
REQ-023 RESTORE SHALL write the stored moved code to from_sq, and the stored captured code to to_sq (or empty if the move was en passant).
REQ-024 The extra undo cycle SHALL move the rook back (5->7 or 3->0), or place {~colour, pawn} on the en-passant square.
REQ-025 Undo with hist_count==0 SHALL pulse err, leave the board unchanged, and keep undo_ready high.
REQ-026 If move_valid and undo_valid are both high in IDLE, undo SHALL win and the move SHALL NOT be accepted.
REQ-027 If moving_piece is not one-hot, the block SHALL pulse err and SHALL NOT accept the move.
REQ-028 init SHALL take priority in every state: on the next edge the board SHALL be loaded, history cleared and FSM set to IDLE, abandoning any operation in flight.

Reset
REQ-029 rst_n low SHALL load the start position: rank 0 white R N B Q K B N R (files 0-7), rank 1 white pawns, rank 6 black pawns, rank 7 black mirror, all other squares empty.
REQ-030 rst_n low SHALL also set hist_count=0, FSM=IDLE, err=0 and busy=0.

Configuration
REQ-031 With PROMOTION_EN defined, a pawn reaching rank 7 (white) or rank 0 (black) SHALL be written as a queen; undo SHALL restore the pawn.
REQ-032 Without PROMOTION_EN, the pawn SHALL remain a pawn on the last rank.

Verification
REQ-033 Reset, then move 12->28 white pawn quiet -> rd 28=000010, rd 12=000000, hist_count=1, ready back after 2 cycles.
REQ-034 White king 4->6 with castling=100 -> 6=000100, 5=010000, 7 and 4 empty; then undo -> original rank 0 restored, hist_count=0.
REQ-035 White pawn on 36, black pawn on 35, move 36->43 with enpassant=00010 -> 35 empty; then undo -> 35=100010, 36=000010, 43 empty.
REQ-036 Undo on empty history -> err high for exactly 1 cycle, board unchanged.
REQ-037 With HIST_DEPTH=2, do 3 moves then 3 undos -> first two undos succeed, third pulses err, hist_count ends at 0.
REQ-038 Assert init during SIDE -> next cycle start position, hist_count=0, IDLE.
